// File: rtl/latch_out_debouncer.sv
// Latch-output debouncer: two-flop synchroniser, stability FSM,
// rise/fall strobes and a saturating transition counter.
module latch_out_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 q_in,
  input  logic                 clear,
  output logic                 q_clean,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] toggle_count,
  output logic                 count_sat
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [SW-1:0] CNT_ZERO = '0;
  localparam logic [SW-1:0] CNT_ONE  = SW'(1);
  localparam logic [SW-1:0] CNT_LAST = SW'(STABLE_CYCLES - 1);

  localparam logic [1:0] IDLE_LOW   = 2'd0;
  localparam logic [1:0] CHECK_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH  = 2'd2;
  localparam logic [1:0] CHECK_LOW  = 2'd3;

  logic                 s1_q;
  logic                 s2_q;
  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [SW-1:0]        cnt_q;
  logic [SW-1:0]        cnt_d;
  logic                 clean_q;
  logic                 clean_d;
  logic                 rise_q;
  logic                 rise_d;
  logic                 fall_q;
  logic                 fall_d;
  logic [CNT_WIDTH-1:0] tcnt_q;
  logic [CNT_WIDTH-1:0] tcnt_d;
  logic                 sat_q;
  logic                 sat_d;

  // q_in is asynchronous; only s2_q may be looked at by the FSM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= q_in;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s2_q) begin
          state_d = CHECK_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      CHECK_HIGH: begin
        if (!s2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = CNT_ZERO;
          clean_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s2_q) begin
          state_d = CHECK_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      CHECK_LOW: begin
        if (s2_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = CNT_ZERO;
          clean_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= CNT_ZERO;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Count from the registered strobes; clear beats a same-cycle increment.
  always_comb begin
    tcnt_d = tcnt_q;
    if (clear) begin
      tcnt_d = '0;
    end else if ((rise_q || fall_q) && !sat_q) begin
      tcnt_d = tcnt_q + CNT_WIDTH'(1);
    end
    sat_d = (tcnt_d == {CNT_WIDTH{1'b1}});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      sat_q  <= sat_d;
    end
  end

  assign q_clean      = clean_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign toggle_count = tcnt_q;
  assign count_sat    = sat_q;

endmodule

// File: tb/tb_latch_out_debouncer.sv
// Directed bench for latch_out_debouncer (STABLE_CYCLES=4,
// CNT_WIDTH=8).
module tb_latch_out_debouncer;

  logic       clock;
  logic       reset_n;
  logic       q_in;
  logic       clear;
  logic       q_clean;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] toggle_count;
  logic       count_sat;

  int checks;
  int failures;
  int rise_seen;
  int fall_seen;
  int both_seen;
  int r0;
  int f0;

  latch_out_debouncer #(
    .STABLE_CYCLES(4),
    .CNT_WIDTH(8)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .q_in(q_in),
    .clear(clear),
    .q_clean(q_clean),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .toggle_count(toggle_count),
    .count_sat(count_sat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rise_pulse) rise_seen++;
    if (fall_pulse) fall_seen++;
    if (rise_pulse && fall_pulse) both_seen++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rise_seen = 0;
    fall_seen = 0;
    both_seen = 0;
    reset_n   = 1'b0;
    q_in      = 1'b0;
    clear     = 1'b0;

    #12;
    chk("rst_clean", 32'(q_clean), 0);
    chk("rst_rise", 32'(rise_pulse), 0);
    chk("rst_fall", 32'(fall_pulse), 0);
    chk("rst_count", 32'(toggle_count), 0);
    chk("rst_sat", 32'(count_sat), 0);
    step(1);
    reset_n = 1'b1;

    // Steady low.
    step(20);
    chk("idle_clean", 32'(q_clean), 0);
    chk("idle_count", 32'(toggle_count), 0);
    chk("idle_pulses", 32'(rise_seen + fall_seen), 0);

    // Accepted rise: strobe after edge 5, count after edge 6.
    q_in = 1'b1;
    step(5);
    chk("rise_early_clean", 32'(q_clean), 0);
    chk("rise_early_pulse", 32'(rise_pulse), 0);
    step(1);
    chk("rise_clean", 32'(q_clean), 1);
    chk("rise_pulse", 32'(rise_pulse), 1);
    chk("rise_cnt_lag", 32'(toggle_count), 0);
    step(1);
    chk("rise_pulse_off", 32'(rise_pulse), 0);
    chk("rise_count", 32'(toggle_count), 1);

    // Accepted fall.
    q_in = 1'b0;
    step(6);
    chk("fall_clean", 32'(q_clean), 0);
    chk("fall_pulse", 32'(fall_pulse), 1);
    chk("fall_no_rise", 32'(rise_pulse), 0);
    step(1);
    chk("fall_pulse_off", 32'(fall_pulse), 0);
    chk("fall_count", 32'(toggle_count), 2);

    // High for only 3 samples: rejected.
    r0 = rise_seen;
    q_in = 1'b1;
    step(3);
    q_in = 1'b0;
    step(10);
    chk("short_hi_clean", 32'(q_clean), 0);
    chk("short_hi_rise", 32'(rise_seen), 32'(r0));
    chk("short_hi_count", 32'(toggle_count), 2);

    // One sample per level, then runs of 3.
    for (int i = 0; i < 40; i++) begin
      q_in = ~q_in;
      step(1);
    end
    for (int i = 0; i < 8; i++) begin
      q_in = ~q_in;
      step(3);
    end
    q_in = 1'b0;
    step(10);
    chk("fast_clean", 32'(q_clean), 0);
    chk("fast_count", 32'(toggle_count), 2);
    chk("fast_pulses", 32'(rise_seen), 32'(r0));

    // Back high, then a 3-sample low glitch.
    q_in = 1'b1;
    step(6);
    chk("rise2_pulse", 32'(rise_pulse), 1);
    step(1);
    chk("rise2_count", 32'(toggle_count), 3);
    f0 = fall_seen;
    q_in = 1'b0;
    step(3);
    q_in = 1'b1;
    step(10);
    chk("short_lo_clean", 32'(q_clean), 1);
    chk("short_lo_fall", 32'(fall_seen), 32'(f0));
    chk("short_lo_count", 32'(toggle_count), 3);

    // 300 transitions: saturate at 255.
    for (int i = 0; i < 300; i++) begin
      q_in = ~q_in;
      step(7);
      if (i == 250) begin
        chk("pre_sat_count", 32'(toggle_count), 254);
        chk("pre_sat_flag", 32'(count_sat), 0);
      end
      if (i == 251) begin
        chk("sat_count", 32'(toggle_count), 255);
        chk("sat_flag", 32'(count_sat), 1);
      end
    end
    chk("sat_hold_count", 32'(toggle_count), 255);
    chk("sat_hold_flag", 32'(count_sat), 1);
    chk("sat_level", 32'(q_clean), 1);

    // Clear together with a fall strobe.
    q_in = 1'b0;
    step(6);
    chk("clr_fall_pulse", 32'(fall_pulse), 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_count", 32'(toggle_count), 0);
    chk("clr_sat", 32'(count_sat), 0);
    chk("clr_keeps_clean", 32'(q_clean), 0);

    // Clear beats an unsaturated increment too.
    q_in = 1'b1;
    step(6);
    chk("clr2_rise", 32'(rise_pulse), 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr2_count", 32'(toggle_count), 0);
    step(1);
    chk("clr2_hold", 32'(toggle_count), 0);
    chk("clr2_clean", 32'(q_clean), 1);

    // Reset while in CHECK_HIGH with cnt=2.
    q_in = 1'b0;
    step(7);
    chk("pre_rst_count", 32'(toggle_count), 1);
    q_in = 1'b1;
    step(4);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_clean", 32'(q_clean), 0);
    chk("mid_rst_count", 32'(toggle_count), 0);
    step(2);
    chk("mid_rst_hold", 32'(rise_pulse), 0);
    reset_n = 1'b1;
    step(5);
    chk("post_rst_early", 32'(q_clean), 0);
    step(1);
    chk("post_rst_clean", 32'(q_clean), 1);
    chk("post_rst_rise", 32'(rise_pulse), 1);
    step(1);
    chk("post_rst_count", 32'(toggle_count), 1);

    chk("never_both", 32'(both_seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/latch_out_debouncer.md
Name: latch_out_debouncer

Overview:
- Downstream consumer of the D-latch output `q`.
- Synchronises `q` into the `clock` domain and rejects pulses shorter than `STABLE_CYCLES`.
- Produces a clean level, one-cycle rise/fall strobes, and a saturating transition counter.
- Sits between the latch stage and any edge-sensitive logic or status readout.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronised samples required to accept a new level (legal range 2..255).
- CNT_WIDTH, 8, width of the transition counter.

Ports:
- clock  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous, active-low reset
- q_in  input  1  raw latch output; asynchronous to `clock`, may glitch
- clear  input  1  synchronous clear of the counter and saturation flag
- q_clean  output  1  debounced, synchronised level
- rise_pulse  output  1  one-cycle strobe when `q_clean` goes 0->1
- fall_pulse  output  1  one-cycle strobe when `q_clean` goes 1->0
- toggle_count  output  CNT_WIDTH  number of accepted transitions, saturating
- count_sat  output  1  high while `toggle_count` is all-ones

Behaviour:
- Reset is asynchronous and active-low on `reset_n`. All logic uses the single `clock`.
- While `reset_n`=0, all of the following are 0 and the FSM is in IDLE_LOW:
  - sync flops s1, s2
  - stability counter
  - `q_clean`, `rise_pulse`, `fall_pulse`, `toggle_count`, `count_sat`
- Synchroniser: at each edge, s1<=q_in and s2<=s1. Only s2 feeds the FSM; `q_in` is never used directly.
- Stability counter: width ceil(log2(STABLE_CYCLES+1)).
- FSM states:
  - IDLE_LOW: if s2=1 -> CHECK_HIGH, cnt<=1; otherwise stay.
  - CHECK_HIGH:
    - s2=0 -> IDLE_LOW, cnt<=0 (glitch rejected, no pulse).
    - s2=1 and cnt=STABLE_CYCLES-1 -> IDLE_HIGH, q_clean<=1, rise_pulse<=1.
    - Otherwise cnt<=cnt+1.
  - IDLE_HIGH: if s2=0 -> CHECK_LOW, cnt<=1; otherwise stay.
  - CHECK_LOW: mirror of CHECK_HIGH.
    - s2=1 -> IDLE_HIGH (glitch rejected).
    - On completion -> IDLE_LOW, q_clean<=0, fall_pulse<=1.
- Pulse width: `rise_pulse` and `fall_pulse` are registered and high for exactly one cycle. They are never both high.
- Latency (edge 0 = first edge sampling q_in=1):
  - `q_in` must be high at edges 0..STABLE_CYCLES-1.
  - `q_clean` and `rise_pulse` go high after edge STABLE_CYCLES+1.
  - The falling direction is symmetric.
- Counter:
  - `toggle_count` increments by 1 in the cycle after each `rise_pulse` or `fall_pulse`, i.e. registered from the pulse.
  - It holds at all-ones, with no wrap.
  - `count_sat` = (toggle_count == all-ones), registered alongside the count.
- Clear: `clear`=1 sets toggle_count<=0 and count_sat<=0 on the next edge. If a pulse-driven increment coincides, clear wins and the result is 0. `clear` does not affect the synchroniser, FSM, or `q_clean`.
- Reset mid-operation: everything returns to 0 immediately and any partial check is discarded. If `q_in`=1 on release, a normal rise is detected after STABLE_CYCLES+1 further edges, and that rise is counted.
- Input toggling faster than STABLE_CYCLES samples: no transition is accepted, `q_clean` holds, and the counter is unchanged.

Test Plan:
1. Reset then steady `q_in`=0 for 20 cycles -> q_clean=0, no pulses, toggle_count=0.
2. `q_in` 0->1 held (STABLE_CYCLES=4) -> q_clean=1 and rise_pulse=1 for one cycle after edge 5; toggle_count=1 one cycle later.
3. `q_in` high for 3 edges, then low -> no rise_pulse, q_clean stays 0, toggle_count=0.
4. 300 accepted transitions (CNT_WIDTH=8) -> toggle_count stops at 255 with count_sat=1; then assert `clear` concurrent with a fall_pulse -> toggle_count=0, count_sat=0.
5. Drive `q_in` from the D latch with d toggling every 10 ns and clock period 10 ns (latch output changes every 10 ns, i.e. one sample per level) -> q_clean never changes, toggle_count=0.
6. Drop `reset_n` in CHECK_HIGH with cnt=2, release with `q_in`=1 -> all outputs 0 during reset; rise accepted after edge 5 post-release; toggle_count=1.
